mem_port_arbiter: RTL

Sequences the single-ported unified memory between the instruction-fetch requester and the data-access requester (loads and stores). The data request carries the memory-stage `DMEM_RW` and `access_size` control, with encodings fixed below. The block grants one requester at a time, holds a registered request on the memory port until acknowledged, and returns read data with a one-cycle done pulse. Misaligned data accesses are rejected without touching memory.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_access_align_check.sv | 23 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter and the memory-stage decoder.
// Access-size codes match the memory-stage access_size control field.
// State and owner encodings are used by the arbiter FSM.
package mem_arb_pkg;

    // Access-size encodings carried on dm_size / mem_size
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_R = 2'b11;  // reserved, always rejected

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-port signals around the arbiter.
// The master view is the arbiter itself (it drives the memory port and the responses);
// the slave view is the environment (requesters plus memory model).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;
    // Data requester
    logic              dm_req;
    logic              dm_rw;
    logic [1:0]        dm_size;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              dm_err;
    logic              dm_stall;
    // Memory port
    logic              mem_req;
    logic              mem_rw;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_done, if_stall,
        input  dm_req, dm_rw, dm_size, dm_addr, dm_wdata,
        output dm_rdata, dm_done, dm_err, dm_stall,
        output mem_req, mem_rw, mem_size, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_done, if_stall,
        output dm_req, dm_rw, dm_size, dm_addr, dm_wdata,
        input  dm_rdata, dm_done, dm_err, dm_stall,
        input  mem_req, mem_rw, mem_size, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_access_align_check.sv
// Flags data accesses whose address is not aligned to their size, or that use the reserved size.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module access_align_check
    import mem_arb_pkg::*;
(
    input  logic [1:0] dm_size,
    input  logic [1:0] dm_addr_lo,
    output logic       misaligned
);

    // Byte is always aligned; half needs bit 0 clear; word needs both low bits clear
    always_comb begin
        misaligned = 1'b1;
        case (dm_size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = dm_addr_lo[0];
            SIZE_W:  misaligned = |dm_addr_lo;
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// Latency: request sampled in cycle 0, mem_req in cycle 1, done one cycle after mem_ack; errors finish in cycle 1.
// Backpressure: requesters hold their request and see stall until their done pulse; memory stalls by withholding mem_ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);

    arb_state_t        state_q;
    owner_t            owner_q;
    logic              last_data_q;
    logic              mem_req_q;
    logic              mem_rw_q;
    logic [1:0]        mem_size_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] resp_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic              dm_err_q;

    logic misaligned;
    logic grant_data;
    logic grant_fetch;

    access_align_check u_align (
        .dm_size    (bus.dm_size),
        .dm_addr_lo (bus.dm_addr[1:0]),
        .misaligned (misaligned)
    );

    // Data wins a tie unless it also won the previous grant, so fetch cannot starve
    always_comb begin
        grant_data  = bus.dm_req && (!bus.if_req || !last_data_q);
        grant_fetch = bus.if_req && !grant_data;
    end

    // Arbiter FSM: grant in IDLE, hold the memory request in BUSY, pulse done in RESP
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            last_data_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_size_q  <= SIZE_W;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            resp_q      <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            dm_err_q    <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            dm_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        owner_q     <= OWN_DATA;
                        last_data_q <= 1'b1;
                        if (misaligned) begin
                            // Rejected without touching memory; respond next cycle
                            state_q   <= RESP;
                            dm_done_q <= 1'b1;
                            dm_err_q  <= 1'b1;
                        end else begin
                            state_q     <= BUSY;
                            mem_req_q   <= 1'b1;
                            mem_rw_q    <= bus.dm_rw;
                            mem_size_q  <= bus.dm_size;
                            mem_addr_q  <= bus.dm_addr;
                            mem_wdata_q <= bus.dm_wdata;
                        end
                    end else if (grant_fetch) begin
                        owner_q     <= OWN_FETCH;
                        last_data_q <= 1'b0;
                        state_q     <= BUSY;
                        mem_req_q   <= 1'b1;
                        mem_rw_q    <= 1'b0;
                        mem_size_q  <= SIZE_W;
                        mem_addr_q  <= bus.if_addr;
                    end
                end
                BUSY: begin
                    // Request fields stay frozen until the memory acknowledges
                    if (bus.mem_ack) begin
                        resp_q    <= bus.mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= RESP;
                        if (owner_q == OWN_DATA) begin
                            dm_done_q <= 1'b1;
                        end else begin
                            if_done_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // Done pulse is visible this cycle; no grant until back in IDLE
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered request and response fields onto the bus
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_size  = mem_size_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = resp_q;
    assign bus.dm_rdata  = resp_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_err    = dm_err_q;

    // Stalls drop in the done cycle so the pipeline advances on that edge
    assign bus.if_stall = bus.if_req && !if_done_q;
    assign bus.dm_stall = bus.dm_req && !dm_done_q;

endmodule
